// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: address-mode encodings,
// access FSM states and default widths.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  localparam logic [2:0] ASEL_PC     = 3'b000;
  localparam logic [2:0] ASEL_ZE_IMM = 3'b001;
  localparam logic [2:0] ASEL_SRC0   = 3'b010;
  localparam logic [2:0] ASEL_SRC1   = 3'b011;
  localparam logic [2:0] ASEL_SP_2   = 3'b100;
  localparam logic [2:0] ASEL_SP_IMM = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_unit_word_ram.sv
// Single-port synchronous word RAM; read data is registered and only updates
// when the port is enabled, so the last read value holds between accesses.
module word_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // read-first port: dout shows the word as it was before a same-cycle write
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[idx] <= din;
      end
      dout <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: selects address and write data, validates the access,
// then runs a fixed-latency access FSM against word_ram with a one-cycle response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int NUM_SRC     = 3,
  parameter int LATENCY     = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [2:0]                   addr_sel,
  input  logic [$clog2(NUM_SRC)-1:0]   data_sel,
  input  logic [ADDR_W-1:0]            pc,
  input  logic [ADDR_W-1:0]            sp_in,
  input  logic [ADDR_W-1:0]            ze_imm,
  input  logic [ADDR_W-1:0]            ls_imm,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr;
  logic               sel_illegal;
  logic [DATA_W-1:0]  wdata;
  logic               acc_err;
  logic               accept;
  logic               leave_access;
  logic               ram_en;
  logic               ram_we;
  logic [IDX_W-1:0]   lat_idx;
  logic [DATA_W-1:0]  lat_wdata;
  logic               lat_write;
  logic               lat_err;
  logic               rsp_zero;
  logic [DATA_W-1:0]  ram_dout;

  // address mode mux; stack adds wrap at ADDR_W bits
  always_comb begin
    addr        = '0;
    sel_illegal = 1'b0;
    case (addr_sel)
      ASEL_PC:     addr = pc;
      ASEL_ZE_IMM: addr = ze_imm;
      ASEL_SRC0:   addr = ADDR_W'(src_data[0 +: DATA_W]);
      ASEL_SRC1:   addr = ADDR_W'(src_data[DATA_W +: DATA_W]);
      ASEL_SP_2:   addr = sp_in + ADDR_W'(2);
      ASEL_SP_IMM: addr = sp_in + ls_imm;
      default:     sel_illegal = 1'b1;
    endcase
  end

  // write-data channel mux; an out-of-range select yields zero
  always_comb begin
    wdata = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      wdata = (data_sel == SEL_W'(k)) ? src_data[k*DATA_W +: DATA_W] : wdata;
    end
  end

  assign acc_err = sel_illegal
                 | ((ALIGN_CHECK != 0) && addr[0])
                 | ({1'b0, addr[ADDR_W-1:1]} >= ADDR_W'(DEPTH))
                 | (req_write && ({1'b0, data_sel} >= (SEL_W+1)'(NUM_SRC)));

  assign req_ready = (state == S_IDLE) && !reset;

  // FSM next state and per-cycle strobes; reset suppresses any commit
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    leave_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !reset) begin
          state_next = S_ACCESS;
          accept     = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          state_next   = S_RESP;
          leave_access = 1'b1;
        end else begin
          state_next = S_ACCESS;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    ram_en = leave_access && !reset;
    ram_we = ram_en && lat_write && !lat_err;
  end

  // state, latency counter, request latch and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_zero  <= 1'b1;
    end else begin
      state     <= state_next;
      rsp_valid <= (state_next == S_RESP);
      if (accept) begin
        cnt       <= CNT_W'(LATENCY - 1);
        lat_idx   <= addr[IDX_W:1];
        lat_wdata <= wdata;
        lat_write <= req_write;
        lat_err   <= acc_err;
      end else if ((state == S_ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        cnt <= cnt;
      end
      if (leave_access) begin
        rsp_err  <= lat_err;
        rsp_zero <= lat_err | lat_write;
      end else begin
        rsp_zero <= rsp_zero;
      end
    end
  end

  // RAM dout only moves when leaving ACCESS, so the masked value holds until the next response
  assign rsp_data = rsp_zero ? '0 : ram_dout;

  word_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (lat_idx),
    .din   (lat_wdata),
    .dout  (ram_dout)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed steps then random requests on a LATENCY=1
// and a LATENCY=3 instance, checked against a word-array model of the RAM.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rv1 = 1'b0;
  logic        rv3 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  addr_sel = 3'd0;
  logic [1:0]  data_sel = 2'd0;
  logic [15:0] pc = 16'h0, sp_in = 16'h0, ze_imm = 16'h0, ls_imm = 16'h0;
  logic [47:0] src_data = 48'h0;
  logic        rdy1, rdy3, vld1, vld3, err1, err3;
  logic [15:0] dat1, dat3;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem1 [int];
  logic [15:0] mem3 [int];

  always #5 clock = ~clock;

  mem_access_unit #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
    .req_write(req_write), .addr_sel(addr_sel), .data_sel(data_sel),
    .pc(pc), .sp_in(sp_in), .ze_imm(ze_imm), .ls_imm(ls_imm), .src_data(src_data),
    .rsp_valid(vld1), .rsp_data(dat1), .rsp_err(err1));

  mem_access_unit #(.LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(rv3), .req_ready(rdy3),
    .req_write(req_write), .addr_sel(addr_sel), .data_sel(data_sel),
    .pc(pc), .sp_in(sp_in), .ze_imm(ze_imm), .ls_imm(ls_imm), .src_data(src_data),
    .rsp_valid(vld3), .rsp_data(dat3), .rsp_err(err3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input int w);
    return (w == 3) ? rdy3 : rdy1;
  endfunction
  function automatic logic f_valid(input int w);
    return (w == 3) ? vld3 : vld1;
  endfunction
  function automatic logic f_err(input int w);
    return (w == 3) ? err3 : err1;
  endfunction
  function automatic logic [15:0] f_data(input int w);
    return (w == 3) ? dat3 : dat1;
  endfunction

  task automatic set_valid(input int w, input logic v);
    if (w == 3) rv3 = v;
    else rv1 = v;
  endtask

  task automatic set_in(input logic [15:0] p, sp, ze, ls, c0, c1, c2);
    pc = p; sp_in = sp; ze_imm = ze; ls_imm = ls; src_data = {c2, c1, c0};
  endtask

  task automatic scramble();
    pc = 16'($urandom); sp_in = 16'($urandom); ze_imm = 16'($urandom);
    ls_imm = 16'($urandom); src_data = 48'({$urandom(), $urandom()});
    addr_sel = 3'($urandom); data_sel = 2'($urandom); req_write = 1'($urandom);
  endtask

  // Model of one request: byte address from the mode rules, then the three error rules
  function automatic void model(input bit wr, input logic [2:0] sel, input logic [1:0] dsel,
                                output bit e, output int idx, output logic [15:0] wd);
    int a;
    bit ill;
    a = 0;
    ill = 1'b0;
    case (sel)
      3'd0: a = int'(pc);
      3'd1: a = int'(ze_imm);
      3'd2: a = int'(src_data[15:0]);
      3'd3: a = int'(src_data[31:16]);
      3'd4: a = (int'(sp_in) + 2) % 65536;
      3'd5: a = (int'(sp_in) + int'(ls_imm)) % 65536;
      default: ill = 1'b1;
    endcase
    e = ill || (a % 2 == 1) || (a / 2 >= 1024) || (wr && dsel >= 2'd3);
    idx = a / 2;
    wd = (dsel == 2'd0) ? src_data[15:0] : (dsel == 2'd1) ? src_data[31:16] :
         (dsel == 2'd2) ? src_data[47:32] : 16'h0;
  endfunction

  task automatic do_op(input int w, input bit wr, input logic [2:0] sel, input logic [1:0] dsel,
                       input bit hold, input bit abort, input string tag);
    bit e;
    bit known;
    int idx;
    int n;
    int lat;
    logic [15:0] wd;
    logic [15:0] exp_d;
    lat = (w == 3) ? 3 : 1;
    req_write = wr; addr_sel = sel; data_sel = dsel;
    model(wr, sel, dsel, e, idx, wd);
    known = 1'b1;
    exp_d = 16'h0;
    if (!e && !wr) begin
      if (w == 3) begin
        known = mem3.exists(idx);
        if (known) exp_d = mem3[idx];
      end else begin
        known = mem1.exists(idx);
        if (known) exp_d = mem1[idx];
      end
    end
    chk({tag, " ready_before"}, 32'(f_ready(w)), 32'd1);
    set_valid(w, 1'b1);
    @(posedge clock);
    #1;
    if (!hold) set_valid(w, 1'b0);
    scramble();
    if (abort) begin
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk({tag, " abort_valid"}, 32'(f_valid(w)), 32'd0);
      chk({tag, " abort_ready"}, 32'(f_ready(w)), 32'd0);
      reset = 1'b0;
      set_valid(w, 1'b0);
      @(negedge clock);
      chk({tag, " after_abort_valid"}, 32'(f_valid(w)), 32'd0);
      chk({tag, " after_abort_ready"}, 32'(f_ready(w)), 32'd1);
      return;
    end
    for (n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (f_valid(w) === 1'b1) break;
      chk({tag, " busy_ready"}, 32'(f_ready(w)), 32'd0);
    end
    chk({tag, " latency"}, 32'(n), 32'(lat + 1));
    chk({tag, " err"}, 32'(f_err(w)), 32'(e));
    if (known) chk({tag, " data"}, 32'(f_data(w)), 32'(exp_d));
    if (hold) set_valid(w, 1'b0);
    if (wr && !e) begin
      if (w == 3) mem3[idx] = wd;
      else mem1[idx] = wd;
    end
    @(negedge clock);
    chk({tag, " pulse_end"}, 32'(f_valid(w)), 32'd0);
    chk({tag, " ready_after"}, 32'(f_ready(w)), 32'd1);
  endtask

  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'($urandom);
    if (r == 1) return 16'(2048 + $urandom_range(0, 15));
    return 16'($urandom_range(0, 63));
  endfunction

  initial begin
    // reset held for two cycles
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("rst1 ready1", 32'(rdy1), 32'd0);
    chk("rst1 valid1", 32'(vld1), 32'd0);
    chk("rst1 ready3", 32'(rdy3), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("rst2 ready1", 32'(rdy1), 32'd0);
    chk("rst2 valid3", 32'(vld3), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst ready1", 32'(rdy1), 32'd1);
    chk("post_rst ready3", 32'(rdy3), 32'd1);
    chk("post_rst valid1", 32'(vld1), 32'd0);
    chk("post_rst err1", 32'(err1), 32'd0);
    chk("post_rst data1", 32'(dat1), 32'd0);

    // write/read at ze_imm
    set_in(16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'hBEEF, 16'h0);
    do_op(1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0, "wr_beef");
    set_in(16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rd_beef");
    chk("rd_beef const", 32'(dat1), 32'h0000BEEF);

    // stack modes
    set_in(16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234);
    do_op(1, 1'b1, 3'b100, 2'd2, 1'b0, 1'b0, "wr_sp2");
    set_in(16'h0, 16'h0, 16'h0102, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rd_0102");
    chk("rd_0102 const", 32'(dat1), 32'h00001234);
    set_in(16'h0, 16'h0100, 16'h0, 16'h0004, 16'h0, 16'h0, 16'h4321);
    do_op(1, 1'b1, 3'b101, 2'd2, 1'b0, 1'b0, "wr_spimm");
    set_in(16'h0, 16'h0, 16'h0104, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rd_0104");
    chk("rd_0104 const", 32'(dat1), 32'h00004321);

    // error cases
    set_in(16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b110, 2'd0, 1'b0, 1'b0, "sel110");
    chk("sel110 err const", 32'(err1), 32'd1);
    set_in(16'h0, 16'h0, 16'h0011, 16'h0, 16'h0, 16'h7777, 16'h0);
    do_op(1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0, "odd_wr");
    set_in(16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rd_unchanged");
    set_in(16'h0, 16'h0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "range");
    set_in(16'h0, 16'h0, 16'h0012, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b1, 3'b001, 2'd3, 1'b0, 1'b0, "dsel3");

    // reset mid-operation discards the pending write
    set_in(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h5555, 16'h0);
    do_op(1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0, "wr_5555");
    set_in(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, 16'hAAAA, 16'h0);
    do_op(1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b1, "wr_abort");
    set_in(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "rd_5555");
    chk("rd_5555 const", 32'(dat1), 32'h00005555);

    // LATENCY=3 with request held through busy period
    set_in(16'h0030, 16'h0, 16'h0, 16'h0, 16'h0, 16'h9999, 16'h0);
    do_op(3, 1'b1, 3'b000, 2'd1, 1'b1, 1'b0, "l3_wr");
    set_in(16'h0030, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(3, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "l3_rd");
    chk("l3_rd const", 32'(dat3), 32'h00009999);
    set_in(16'h0, 16'h0, 16'h0031, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(3, 1'b0, 3'b001, 2'd0, 1'b0, 1'b0, "l3_odd");

    // randomized requests on both instances
    for (int i = 0; i < 60; i++) begin
      set_in(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr(),
             16'($urandom));
      do_op((i % 2 == 0) ? 1 : 3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
